// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the data-memory DMA engine.
//   dma_state_t : engine FSM states, also exported on the debug port
//   dma_mode_t  : request type (COPY src->dst, FILL dst with a constant)
//   WORD_BYTES  : bytes per memory word; byte addresses step by this
package mem_dma_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    RD_CAP = 3'd2,
    WR     = 3'd3,
    FIN    = 3'd4
  } dma_state_t;

  typedef enum logic {
    DMA_COPY = 1'b0,
    DMA_FILL = 1'b1
  } dma_mode_t;

endpackage

// File: rtl/mem_dma_engine_if.sv
// Word-addressed data-memory port shared by the CPU and the DMA engine.
//   MA  : byte address          MWD : write data
//   MWR : write enable          MOE : read enable
//   MRD : read data
// Bus semantics: MOE=1 requests the word at MA and MRD carries it in the
// following cycle (registered read). MWR=1 commits MWD at MA on the rising
// edge of that cycle. There is no back-pressure: the memory always accepts,
// and MOE and MWR are never asserted together.
interface mem_dma_engine_if;
  logic [31:0] MA;
  logic [31:0] MWD;
  logic        MWR;
  logic        MOE;
  logic [31:0] MRD;

  modport master (output MA, output MWD, output MWR, output MOE, input MRD);
  modport slave  (input MA, input MWD, input MWR, input MOE, output MRD);
endinterface

// File: rtl/mem_dma_range_chk.sv
// Combinational alignment and bounds check for one block address.
//   i_en   : 1 = check this address, 0 = force o_bad low
//   i_addr : byte address of the first word of the block
//   i_len  : block length in words
//   o_bad  : address misaligned or block runs past the end of memory
module mem_dma_range_chk
  import mem_dma_pkg::*;
#(
  parameter int MEM_WORDS = 32,
  parameter int LEN_W     = 6
) (
  input  logic             i_en,
  input  logic [31:0]      i_addr,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_bad
);

  localparam int ADDR_LSB = $clog2(WORD_BYTES);
  // Wide enough for a 30-bit word index plus len without wrapping.
  localparam int SUM_W    = 33;

  logic [SUM_W-1:0] w_end;
  logic             w_misal;
  logic             w_oor;

  assign w_end   = SUM_W'(i_addr >> ADDR_LSB) + SUM_W'(i_len);
  assign w_misal = (i_addr[ADDR_LSB-1:0] != '0);
  assign w_oor   = (w_end > SUM_W'(MEM_WORDS));
  assign o_bad   = i_en & (w_misal | w_oor);

endmodule

// File: rtl/mem_dma_engine.sv
// DMA engine: copies or fills a block of 32-bit words in data memory.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start, mode         : request strobe (sampled in IDLE), 0=COPY 1=FILL
//   src_addr, dst_addr  : byte addresses of source / destination blocks
//   len, fill_val       : word count, FILL data
//   abort               : stop a running transfer without done
//   busy, done, err     : status; done is a 1-cycle pulse, err held
//   words_done          : words written in current/last transfer
//   mem                 : memory bus master (MA/MWD/MWR/MOE -> MRD)
//   dbg_state           : current FSM state
module mem_dma_engine
  import mem_dma_pkg::*;
#(
  parameter int MEM_WORDS = 32,
  parameter int LEN_W     = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [31:0]         src_addr,
  input  logic [31:0]         dst_addr,
  input  logic [LEN_W-1:0]    len,
  input  logic [31:0]         fill_val,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [LEN_W-1:0]    words_done,
  mem_dma_engine_if.master    mem,
  output dma_state_t          dbg_state
);

  localparam logic [31:0] STEP = 32'(WORD_BYTES);

  dma_state_t       r_state, w_state_nxt;
  dma_mode_t        r_mode, w_mode_nxt;
  logic [31:0]      r_src, w_src_nxt;
  logic [31:0]      r_dst, w_dst_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic [31:0]      r_fill, w_fill_nxt;
  logic [LEN_W-1:0] r_words, w_words_nxt;
  logic             r_err, w_err_nxt;
  // Bus outputs are registered from the next state so they are valid for the
  // whole cycle the corresponding state is current.
  logic [31:0]      r_ma, w_ma_nxt;
  logic [31:0]      r_mwd, w_mwd_nxt;
  logic             r_mwr, w_mwr_nxt;
  logic             r_moe, w_moe_nxt;

  logic             w_src_bad;
  logic             w_dst_bad;
  logic [LEN_W-1:0] w_words_inc;
  dma_mode_t        w_req_mode;

  assign w_req_mode  = dma_mode_t'(mode);
  assign w_words_inc = r_words + LEN_W'(1);

  // Source is only meaningful for COPY, so its check is disabled for FILL.
  mem_dma_range_chk #(.MEM_WORDS(MEM_WORDS), .LEN_W(LEN_W)) u_src_chk (
    .i_en   (w_req_mode == DMA_COPY),
    .i_addr (src_addr),
    .i_len  (len),
    .o_bad  (w_src_bad)
  );

  mem_dma_range_chk #(.MEM_WORDS(MEM_WORDS), .LEN_W(LEN_W)) u_dst_chk (
    .i_en   (1'b1),
    .i_addr (dst_addr),
    .i_len  (len),
    .o_bad  (w_dst_bad)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_src_nxt   = r_src;
    w_dst_nxt   = r_dst;
    w_len_nxt   = r_len;
    w_fill_nxt  = r_fill;
    w_words_nxt = r_words;
    w_err_nxt   = r_err;
    w_ma_nxt    = '0;
    w_mwd_nxt   = '0;
    w_mwr_nxt   = 1'b0;
    w_moe_nxt   = 1'b0;

    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_mode_nxt  = w_req_mode;
          w_src_nxt   = src_addr;
          w_dst_nxt   = dst_addr;
          w_len_nxt   = len;
          w_fill_nxt  = fill_val;
          w_words_nxt = '0;
          w_err_nxt   = 1'b0;
          if (len == '0) begin
            w_state_nxt = FIN;
          end else if (w_src_bad || w_dst_bad) begin
            w_state_nxt = FIN;
            w_err_nxt   = 1'b1;
          end else if (w_req_mode == DMA_COPY) begin
            w_state_nxt = RD_REQ;
            w_ma_nxt    = src_addr;
            w_moe_nxt   = 1'b1;
          end else begin
            w_state_nxt = WR;
            w_ma_nxt    = dst_addr;
            w_mwd_nxt   = fill_val;
            w_mwr_nxt   = 1'b1;
          end
        end
      end

      RD_REQ: begin
        w_state_nxt = abort ? IDLE : RD_CAP;
      end

      // The MWD register doubles as the captured read data for the write.
      RD_CAP: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WR;
          w_ma_nxt    = r_dst;
          w_mwd_nxt   = mem.MRD;
          w_mwr_nxt   = 1'b1;
        end
      end

      // The word is committed at this edge even under abort, so it is counted.
      WR: begin
        w_words_nxt = w_words_inc;
        w_src_nxt   = r_src + STEP;
        w_dst_nxt   = r_dst + STEP;
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (w_words_inc == r_len) begin
          w_state_nxt = FIN;
        end else if (r_mode == DMA_COPY) begin
          w_state_nxt = RD_REQ;
          w_ma_nxt    = r_src + STEP;
          w_moe_nxt   = 1'b1;
        end else begin
          w_state_nxt = WR;
          w_ma_nxt    = r_dst + STEP;
          w_mwd_nxt   = r_fill;
          w_mwr_nxt   = 1'b1;
        end
      end

      FIN: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_mode  <= DMA_COPY;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_fill  <= '0;
      r_words <= '0;
      r_err   <= 1'b0;
      r_ma    <= '0;
      r_mwd   <= '0;
      r_mwr   <= 1'b0;
      r_moe   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_src   <= w_src_nxt;
      r_dst   <= w_dst_nxt;
      r_len   <= w_len_nxt;
      r_fill  <= w_fill_nxt;
      r_words <= w_words_nxt;
      r_err   <= w_err_nxt;
      r_ma    <= w_ma_nxt;
      r_mwd   <= w_mwd_nxt;
      r_mwr   <= w_mwr_nxt;
      r_moe   <= w_moe_nxt;
    end
  end

  assign busy       = (r_state == RD_REQ) || (r_state == RD_CAP) || (r_state == WR);
  assign done       = (r_state == FIN);
  assign err        = r_err;
  assign words_done = r_words;
  assign dbg_state  = r_state;

  assign mem.MA  = r_ma;
  assign mem.MWD = r_mwd;
  assign mem.MWR = r_mwr;
  assign mem.MOE = r_moe;

endmodule

// File: tb/tb_mem_dma_engine.sv
module tb_mem_dma_engine;
  import mem_dma_pkg::*;

  localparam int MEM_WORDS = 32;
  localparam int LEN_W     = 6;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             start, mode, abort;
  logic [31:0]      src_addr, dst_addr, fill_val;
  logic [LEN_W-1:0] len;
  logic             busy, done, err;
  logic [LEN_W-1:0] words_done;
  dma_state_t       dbg_state;

  mem_dma_engine_if bus();

  mem_dma_engine #(.MEM_WORDS(MEM_WORDS), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .fill_val   (fill_val),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .words_done (words_done),
    .mem        (bus),
    .dbg_state  (dbg_state)
  );

  // Registered-read data memory attached to the bus.
  logic [31:0] dmem    [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  always @(posedge clk) begin
    if (bus.MWR) dmem[bus.MA[6:2]] <= bus.MWD;
    bus.MRD <= dmem[bus.MA[6:2]];
  end

  // ---------------- scoreboard ----------------
  logic [63:0]      exp_q[$];       // expected writes {MA, MWD}
  logic [LEN_W:0]   exp_done_q[$];  // expected {err, words_done} at done
  int n_cmp  = 0;
  int n_fail = 0;
  bit both_seen = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT writes or signals done.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.MWR && bus.MOE) both_seen = 1'b1;
      if (bus.MWR) begin
        if (exp_q.size() == 0) check("unexpected_write", {bus.MA, bus.MWD}, 64'hX);
        else check("write", {bus.MA, bus.MWD}, exp_q.pop_front());
      end
      if (done) begin
        if (exp_done_q.size() == 0) check("unexpected_done", 64'({err, words_done}), 64'hX);
        else check("done_status", 64'({err, words_done}), 64'(exp_done_q.pop_front()));
      end
    end
  end

  // ---------------- reference model ----------------
  // Applies a request to ref_mem word by word in ascending order. limit caps
  // the writes the bus shows, commit_limit caps the writes that land.
  task automatic model_req(input logic m, input logic [31:0] s, input logic [31:0] d,
                           input logic [LEN_W-1:0] l, input logic [31:0] f,
                           input int limit, input int commit_limit, input bit expect_done,
                           output int exp_cyc, output logic exp_err);
    longint s_end, d_end;
    bit bad;
    logic [31:0] v;
    s_end = longint'(s >> 2) + longint'(l);
    d_end = longint'(d >> 2) + longint'(l);
    bad = (d[1:0] != 2'b00) || (d_end > MEM_WORDS) ||
          (m == 1'b0 && ((s[1:0] != 2'b00) || (s_end > MEM_WORDS)));
    if (l == '0) begin
      exp_err = 1'b0;
      exp_cyc = 1;
      if (expect_done) exp_done_q.push_back({1'b0, LEN_W'(0)});
    end else if (bad) begin
      exp_err = 1'b1;
      exp_cyc = 1;
      if (expect_done) exp_done_q.push_back({1'b1, LEN_W'(0)});
    end else begin
      for (int i = 0; i < int'(l) && i < limit; i++) begin
        v = m ? f : ref_mem[int'(s >> 2) + i];
        if (i < commit_limit) ref_mem[int'(d >> 2) + i] = v;
        exp_q.push_back({d + 32'(4 * i), v});
      end
      exp_err = 1'b0;
      exp_cyc = m ? int'(l) + 1 : 3 * int'(l) + 1;
      if (expect_done) exp_done_q.push_back({1'b0, l});
    end
  endtask

  // ---------------- drivers ----------------
  int mwr_cyc_q[$];
  int moe_cnt;
  bit busy_c1;

  // Called at a negedge; returns at the negedge of cycle 1.
  task automatic drive_start(input logic m, input logic [31:0] s, input logic [31:0] d,
                             input logic [LEN_W-1:0] l, input logic [31:0] f);
    mode = m; src_addr = s; dst_addr = d; len = l; fill_val = f;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int dcyc);
    int cyc;
    dcyc = -1;
    mwr_cyc_q.delete();
    moe_cnt = 0;
    busy_c1 = busy;
    cyc = 1;
    while (cyc <= 400) begin
      if (bus.MOE) moe_cnt++;
      if (bus.MWR) mwr_cyc_q.push_back(cyc);
      if (done) begin
        dcyc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_req(input string tag, input logic m, input logic [31:0] s,
                         input logic [31:0] d, input logic [LEN_W-1:0] l, input logic [31:0] f);
    int ec, dc;
    logic ee;
    model_req(m, s, d, l, f, 1000, 1000, 1'b1, ec, ee);
    drive_start(m, s, d, l, f);
    wait_done(dc);
    check({tag, "_done_cycle"}, 64'(dc), 64'(ec));
    check({tag, "_busy_c1"}, 64'(busy_c1), 64'(ec > 1));
    @(negedge clk);
    check({tag, "_err_held"}, 64'(err), 64'(ee));
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int ec, c;
    int mwr_cnt, done_cnt;
    logic ee;
    logic m;
    logic [31:0] s, d;
    logic [LEN_W-1:0] l;

    rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0; fill_val = '0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      dmem[i]    = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
      ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    end
    dmem[1] = 32'hA;  ref_mem[1] = 32'hA;
    dmem[2] = 32'h38; ref_mem[2] = 32'h38;
    dmem[3] = 32'h0;  ref_mem[3] = 32'h0;

    @(negedge clk); @(negedge clk);
    check("reset_ctrl", 64'({busy, done, err, words_done, bus.MWR, bus.MOE}), 64'(0));
    check("reset_bus", {bus.MA, bus.MWD}, 64'(0));
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // 1: COPY of three preset words
    run_req("copy3", 1'b0, 32'h04, 32'h40, 6'd3, 32'h0);
    check("copy3_mwr_cycles", mwr_cyc_q.size() == 3 ? {mwr_cyc_q[0][15:0], mwr_cyc_q[1][15:0], mwr_cyc_q[2][15:0]} : 64'hFFFF,
          {16'd3, 16'd6, 16'd9});
    check("copy3_words_done", 64'(words_done), 64'(3));
    check("copy3_mem", {dmem[16], dmem[17]}, {32'hA, 32'h38});
    check("copy3_mem18", 64'(dmem[18]), 64'(0));

    // 2: FILL four words
    run_req("fill4", 1'b1, 32'h0, 32'h50, 6'd4, 32'hDEADBEEF);
    check("fill4_mwr_cnt", 64'(mwr_cyc_q.size()), 64'(4));
    check("fill4_mwr_first", mwr_cyc_q.size() > 0 ? 64'(mwr_cyc_q[0]) : 64'hFFFF, 64'(1));
    check("fill4_moe", 64'(moe_cnt), 64'(0));
    check("fill4_mem", {dmem[20], dmem[23]}, {32'hDEADBEEF, 32'hDEADBEEF});

    // 3: zero length
    run_req("len0", 1'b0, 32'h04, 32'h40, 6'd0, 32'h0);
    check("len0_access", 64'({mwr_cyc_q.size() == 0, moe_cnt == 0}), 64'(2'b11));

    // 4: rejected requests
    run_req("misal", 1'b0, 32'h06, 32'h40, 6'd2, 32'h0);
    check("misal_mwr", 64'(mwr_cyc_q.size()), 64'(0));
    run_req("range", 1'b1, 32'h0, 32'h78, 6'd3, 32'h77);
    check("range_mwr", 64'(mwr_cyc_q.size()), 64'(0));

    // 5: abort while reading the second word, plus an ignored start
    model_req(1'b0, 32'h04, 32'h60, 6'd4, 32'h0, 1, 1, 1'b0, ec, ee);
    drive_start(1'b0, 32'h04, 32'h60, 6'd4, 32'h0);
    mwr_cnt = 0; done_cnt = 0;
    for (c = 1; c <= 10; c++) begin
      if (bus.MWR) mwr_cnt++;
      if (done) done_cnt++;
      if (c == 2) begin
        start = 1'b1; mode = 1'b1; dst_addr = 32'h0; len = 6'd5; fill_val = 32'h55;
      end
      if (c == 3) start = 1'b0;
      if (c == 5) abort = 1'b1;
      if (c == 6) begin
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_words_done", 64'(words_done), 64'(1));
      end
      @(negedge clk);
    end
    check("abort_mwr_cnt", 64'(mwr_cnt), 64'(1));
    check("abort_no_done", 64'(done_cnt), 64'(0));

    // 6: reset during the second write of a FILL
    model_req(1'b1, 32'h0, 32'h70, 6'd4, 32'h12345678, 2, 1, 1'b0, ec, ee);
    drive_start(1'b1, 32'h0, 32'h70, 6'd4, 32'h12345678);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_ctrl", 64'({busy, done, err, words_done, bus.MWR, bus.MOE}), 64'(0));
    check("rst_mid_bus", {bus.MA, bus.MWD}, 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_word_kept", 64'(dmem[29]), 64'(ref_mem[29]));

    // Random requests against the model
    for (int n = 0; n < 40; n++) begin
      m = 1'($urandom_range(0, 1));
      s = 32'($urandom_range(0, 31)) * 4;
      if ($urandom_range(0, 7) == 0) s = s + 32'($urandom_range(1, 3));
      d = 32'($urandom_range(0, 31)) * 4;
      if ($urandom_range(0, 7) == 0) d = d + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) d = 32'hFFFF_FFF0;
      if ($urandom_range(0, 7) == 0) l = LEN_W'($urandom_range(0, 40));
      else l = LEN_W'($urandom_range(1, 8));
      run_req("rand", m, s, d, l, $urandom);
    end

    // Final state
    repeat (3) @(negedge clk);
    for (int i = 0; i < MEM_WORDS; i++) check($sformatf("mem_%0d", i), 64'(dmem[i]), 64'(ref_mem[i]));
    check("moe_mwr_overlap", 64'(both_seen), 64'(0));
    check("exp_writes_left", 64'(exp_q.size()), 64'(0));
    check("exp_done_left", 64'(exp_done_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
